// File: rtl/adder_pkg.sv
// Shared constants and a reference sum helper for the registered ripple-carry adder.
package adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   function automatic logic [DEFAULT_WIDTH:0] expected_sum(
      input logic [DEFAULT_WIDTH-1:0] a,
      input logic [DEFAULT_WIDTH-1:0] b
   );
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational; chained to form the ripple-carry sum.
module full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/adder_8bit.sv
// Registered unsigned adder: a ripple chain of full_adder_cell instances feeding a
// one-cycle output register; res[WIDTH] carries the final carry-out.
module adder_8bit
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH:0]   res
);

   logic [WIDTH:0] carry;
   logic [WIDTH:0] sum;

   assign carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder_cell u_fa (
         .x    (a[i]),
         .y    (b[i]),
         .cin  (carry[i]),
         .s    (sum[i]),
         .cout (carry[i+1])
      );
   end

   assign sum[WIDTH] = carry[WIDTH];

   // res only loads on valid cycles, so garbage on a/b while idle never reaches it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            res <= sum;
         end
      end
   end

endmodule

// File: tb/tb_adder_8bit.sv
// Directed bench for adder_8bit: hand-computed sums, carry-out, streaming, hold and async reset.
module tb_adder_8bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic [8:0] res;

   int vectors = 0;
   int errors  = 0;

   adder_8bit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .res       (res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv);
      in_valid = v;
      a        = av;
      b        = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      a        = 8'd5;
      b        = 8'd5;
      #3;
      vectors++;
      if (res !== 9'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async res=%0d ov=%b want res=0 ov=0", res, out_valid);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (res !== 9'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold res=%0d ov=%b want res=0 ov=0", res, out_valid);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (res !== 9'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release res=%0d ov=%b want res=0 ov=0", res, out_valid);
      end
   endtask

   task automatic test_zero();
      drive(1'b1, 8'd0, 8'd0);
      vectors++;
      if (res !== 9'b000000000 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL zero res=%0d ov=%b want res=0 ov=1", res, out_valid);
      end
   endtask

   task automatic test_basic();
      drive(1'b1, 8'd100, 8'd77);
      vectors++;
      if (res !== 9'b010110001 || res[8] !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL sum_100_77 res=%0d ov=%b want res=177 ov=1", res, out_valid);
      end
      drive(1'b1, 8'd70, 8'd35);
      vectors++;
      if (res !== 9'b001101001 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL sum_70_35 res=%0d ov=%b want res=105 ov=1", res, out_valid);
      end
      drive(1'b1, 8'h55, 8'hAA);
      vectors++;
      if (res !== 9'd255) begin
         errors++;
         $display("FAIL sum_55_aa res=%0d want res=255", res);
      end
   endtask

   task automatic test_carry();
      drive(1'b1, 8'd255, 8'd255);
      vectors++;
      if (res !== 9'd510 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL carry_255_255 res=%0d ov=%b want res=510 ov=1", res, out_valid);
      end
      drive(1'b1, 8'd128, 8'd128);
      vectors++;
      if (res !== 9'd256 || res[8] !== 1'b1) begin
         errors++;
         $display("FAIL carry_128_128 res=%0d want res=256 res8=1", res);
      end
      drive(1'b1, 8'd255, 8'd1);
      vectors++;
      if (res !== 9'd256) begin
         errors++;
         $display("FAIL carry_ripple res=%0d want res=256", res);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 8'd1, 8'd2);
      vectors++;
      if (res !== 9'd3 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stream_0 res=%0d ov=%b want res=3 ov=1", res, out_valid);
      end
      drive(1'b1, 8'd3, 8'd4);
      vectors++;
      if (res !== 9'd7 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stream_1 res=%0d ov=%b want res=7 ov=1", res, out_valid);
      end
      drive(1'b1, 8'd200, 8'd100);
      vectors++;
      if (res !== 9'd300 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL stream_2 res=%0d ov=%b want res=300 ov=1", res, out_valid);
      end
      drive(1'b0, 8'bx, 8'bz);
      vectors++;
      if (res !== 9'd300 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold res=%0d ov=%b want res=300 ov=0", res, out_valid);
      end
      drive(1'b0, 8'd9, 8'd9);
      vectors++;
      if (res !== 9'd300 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold2 res=%0d ov=%b want res=300 ov=0", res, out_valid);
      end
   endtask

   task automatic test_between_edges();
      drive(1'b1, 8'd10, 8'd20);
      a = 8'd90;
      b = 8'd90;
      #3;
      vectors++;
      if (res !== 9'd30) begin
         errors++;
         $display("FAIL between_edges res=%0d want res=30", res);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (res !== 9'd180 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL after_edge res=%0d ov=%b want res=180 ov=1", res, out_valid);
      end
   endtask

   task automatic test_reset_mid_stream();
      drive(1'b1, 8'd50, 8'd60);
      vectors++;
      if (res !== 9'd110 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset res=%0d ov=%b want res=110 ov=1", res, out_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (res !== 9'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid res=%0d ov=%b want res=0 ov=0", res, out_valid);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (res !== 9'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hold res=%0d ov=%b want res=0 ov=0", res, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'd4, 8'd5);
      vectors++;
      if (res !== 9'd9 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset res=%0d ov=%b want res=9 ov=1", res, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_basic();
      test_carry();
      test_back_to_back();
      test_between_edges();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
